truth_table_reader: RTL

TRUTH_TABLE_READER -- requirements
Module: truth_table_reader

---
 rtl/truth_table_reader.sv | 109 ++++++++++
 1 files changed

// File: rtl/truth_table_reader.sv
// Sweeps all 2**N input rows of an external combinational function and captures SoP/PoS masks.
// Optional compare port pair enabled by `define TTR_COMPARE_EN; latency 2*(2**N)+1 cycles start->done.
module truth_table_reader #(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                f_in,
`ifdef TTR_COMPARE_EN
    input  logic [(1<<N)-1:0]   expected,
    output logic                match,
`endif
    output logic [N-1:0]        x_out,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   minterms,
    output logic [(1<<N)-1:0]   maxterms,
    output logic [N:0]          ones_cnt
);

    localparam int ROWS = 1 << N;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [ROWS-1:0] min_q, min_d;
    logic [N:0]      ones_q, ones_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        min_d   = min_q;
        ones_d  = ones_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    min_d   = '0;
                    ones_d  = '0;
                end
            end
            S_DRIVE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                min_d[idx_q] = f_in;
                ones_d       = ones_q + {{N{1'b0}}, f_in};
                // Terminal row always ends the sweep, so the index never wraps.
                if (idx_q == N'(ROWS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + N'(1);
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            min_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            min_q   <= min_d;
            ones_q  <= ones_d;
        end
    end

`ifdef TTR_COMPARE_EN
    logic match_q, match_d;

    // Evaluated with the final row folded in so the result is visible during DONE.
    always_comb begin
        match_d = match_q;
        if (state_q == S_IDLE && start) begin
            match_d = 1'b0;
        end else if (state_q == S_SAMPLE && state_d == S_DONE) begin
            match_d = (min_d == expected);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

    assign busy     = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done     = (state_q == S_DONE);
    assign x_out    = busy ? idx_q : '0;
    assign minterms = min_q;
    assign maxterms = ~min_q;
    assign ones_cnt = ones_q;

endmodule
